// File: rtl/board_reset_ctrl.sv
// board_reset_ctrl: merges PLL locks and raw buttons into one stretched system reset.
// Optional watchdog is compiled in when BOARD_RESET_WDT_EN is defined.
module board_reset_ctrl #(
    parameter int                     NUM_LOCKS       = 2,
    parameter int                     NUM_BUTTONS     = 2,
    parameter logic [NUM_BUTTONS-1:0] RESET_BTN_MASK  = 'b1,
    parameter int                     DEBOUNCE_CYCLES = 500000,
    parameter int                     HOLD_CYCLES     = 1024,
    parameter int                     WDT_CYCLES      = 2**26
) (
    input  logic                   clk,
    input  logic                   reset_n_i,
    input  logic [NUM_LOCKS-1:0]   locked_i,
    input  logic [NUM_BUTTONS-1:0] button_n_i,
    input  logic                   wdt_kick_i,
    output logic                   reset_o,
    output logic                   ready_o,
    output logic [NUM_BUTTONS-1:0] button_o,
    output logic [NUM_BUTTONS-1:0] pressed_o,
    output logic                   wdt_fired_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ASSERT,
        HOLD,
        RUN
    } state_t;

    // Async assert, sync deassert of the internal reset
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync <= '0;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic [NUM_LOCKS-1:0]   lock_s1, lock_s2;
    logic [NUM_BUTTONS-1:0] btn_s1, btn_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1 <= '0;
            lock_s2 <= '0;
            btn_s1  <= '1;
            btn_s2  <= '1;
        end else begin
            lock_s1 <= locked_i;
            lock_s2 <= lock_s1;
            btn_s1  <= button_n_i;
            btn_s2  <= btn_s1;
        end
    end

    logic [DW-1:0]          db_cnt   [NUM_BUTTONS];
    logic [DW-1:0]          db_cnt_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] btn_lvl, btn_d;

    assign btn_lvl = ~btn_s2;

    always_comb begin
        btn_d = button_o;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt_d[i] = '0;
            if (btn_lvl[i] != button_o[i]) begin
                if (db_cnt[i] == DB_LAST) btn_d[i] = btn_lvl[i];
                else                      db_cnt_d[i] = db_cnt[i] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_o  <= '0;
            pressed_o <= '0;
            db_cnt    <= '{default: '0};
        end else begin
            button_o  <= btn_d;
            pressed_o <= btn_d & ~button_o;
            db_cnt    <= db_cnt_d;
        end
    end

    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          all_locked, rst_btn, wdt_hit;

    assign all_locked = &lock_s2;
    // Uses the next debounced level so the FSM reacts on the toggle edge
    assign rst_btn    = |(btn_d & RESET_BTN_MASK);

`ifdef BOARD_RESET_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES) + 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdt_cnt;

    assign wdt_hit = (state_q == RUN) && !wdt_kick_i && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt     <= '0;
            wdt_fired_o <= 1'b0;
        end else begin
            if (state_q != RUN || wdt_kick_i || wdt_hit) wdt_cnt <= '0;
            else                                         wdt_cnt <= wdt_cnt + WW'(1);
            if (wdt_hit) wdt_fired_o <= 1'b1;
        end
    end
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic unused_wdt_kick;

    assign unused_wdt_kick = wdt_kick_i;
    assign wdt_hit         = 1'b0;
    assign wdt_fired_o     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        unique case (state_q)
            ASSERT: if (all_locked && !rst_btn) state_d = HOLD;
            HOLD: begin
                if (!all_locked || rst_btn)  state_d = ASSERT;
                else if (hold_cnt == HOLD_LAST) state_d = RUN;
                else                         hold_d = hold_cnt + HW'(1);
            end
            RUN: if (!all_locked || rst_btn || wdt_hit) state_d = ASSERT;
            default: state_d = ASSERT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ASSERT;
            hold_cnt <= '0;
            reset_o  <= 1'b1;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_cnt <= hold_d;
            reset_o  <= (state_d != RUN);
            ready_o  <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_board_reset_ctrl.sv
// tb_board_reset_ctrl: directed scoreboard bench for board_reset_ctrl.
// Define BOARD_RESET_WDT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_board_reset_ctrl;

    localparam int NL   = 2;
    localparam int NB   = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 16;
    localparam int WDT  = 100;
    localparam int LOCK_LAT = HOLD + 3;
    localparam int DEB_LAT  = DEB + 2;

    localparam int S_RST   = 0;
    localparam int S_RDY   = 1;
    localparam int S_BTN   = 2;
    localparam int S_PRS   = 3;
    localparam int S_FIRED = 4;
    localparam int S_PCNT  = 5;
    localparam int S_RSEEN = 6;
    localparam int S_YSEEN = 7;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic [NL-1:0] locked_i;
    logic [NB-1:0] button_n_i;
    logic          wdt_kick_i;
    logic          reset_o;
    logic          ready_o;
    logic [NB-1:0] button_o;
    logic [NB-1:0] pressed_o;
    logic          wdt_fired_o;

    always #5 clk = ~clk;

    board_reset_ctrl #(
        .NUM_LOCKS      (NL),
        .NUM_BUTTONS    (NB),
        .RESET_BTN_MASK (2'b01),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .locked_i   (locked_i),
        .button_n_i (button_n_i),
        .wdt_kick_i (wdt_kick_i),
        .reset_o    (reset_o),
        .ready_o    (ready_o),
        .button_o   (button_o),
        .pressed_o  (pressed_o),
        .wdt_fired_o(wdt_fired_o)
    );

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   press_cnt;
    logic rst_seen;
    logic rdy_seen;
    logic mon_en;

    task automatic expect_val(input string tag, input int sel, input logic [7:0] e);
        sb.push_back('{tag, sel, e});
    endtask

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            S_RST:   return {7'b0, reset_o};
            S_RDY:   return {7'b0, ready_o};
            S_BTN:   return {6'b0, button_o};
            S_PRS:   return {6'b0, pressed_o};
            S_FIRED: return {7'b0, wdt_fired_o};
            S_PCNT:  return 8'(press_cnt);
            S_RSEEN: return {7'b0, rst_seen};
            S_YSEEN: return {7'b0, rdy_seen};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic check_all();
        while (sb.size() > 0) begin
            exp_t       x = sb.pop_front();
            logic [7:0] o = obs(x.sel);
            n_checks++;
            assert (o === x.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", x.tag, o, x.exp);
            end
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (pressed_o != '0) press_cnt++;
                if (reset_o) rst_seen = 1'b1;
                if (ready_o) rdy_seen = 1'b1;
            end
        end
    endtask

    task automatic kick();
        wdt_kick_i = 1'b1;
        step(1);
        wdt_kick_i = 1'b0;
    endtask

    initial begin
        reset_n_i  = 1'b0;
        locked_i   = '0;
        button_n_i = '1;
        wdt_kick_i = 1'b0;
        mon_en     = 1'b0;
        press_cnt  = 0;
        rst_seen   = 1'b0;
        rdy_seen   = 1'b0;

        // Reset values
        step(3);
        expect_val("rst_reset_o", S_RST, 1);
        expect_val("rst_ready_o", S_RDY, 0);
        expect_val("rst_button_o", S_BTN, 0);
        expect_val("rst_pressed_o", S_PRS, 0);
        expect_val("rst_wdt_fired", S_FIRED, 0);
        check_all();

        reset_n_i = 1'b1;
        step(4);
        expect_val("unlocked_reset_o", S_RST, 1);
        check_all();

        // 1: lock -> reset_o falls HOLD+3 edges later
        locked_i = '1;
        expect_val("t1_reset_before", S_RST, 1);
        expect_val("t1_ready_before", S_RDY, 0);
        step(LOCK_LAT - 1);
        check_all();
        expect_val("t1_reset_after", S_RST, 0);
        expect_val("t1_ready_after", S_RDY, 1);
        step(1);
        check_all();

        // 2: lock glitch at hold count 10 restarts hold
        locked_i = '0;
        expect_val("t2_drop_reset", S_RST, 1);
        step(3);
        check_all();
        step(2);
        locked_i = '1;
        step(13);
        locked_i[1] = 1'b0;
        step(1);
        locked_i[1] = 1'b1;
        mon_en = 1'b1;
        rdy_seen = 1'b0;
        expect_val("t2_no_early_run", S_YSEEN, 0);
        expect_val("t2_reset_before", S_RST, 1);
        step(LOCK_LAT - 1);
        check_all();
        mon_en = 1'b0;
        expect_val("t2_reset_after", S_RST, 0);
        expect_val("t2_ready_after", S_RDY, 1);
        step(1);
        check_all();

        // 3: bouncy non-reset button
        press_cnt = 0;
        rst_seen  = 1'b0;
        mon_en    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            button_n_i[1] = ~button_n_i[1];
            step(3);
        end
        button_n_i[1] = 1'b0;
        expect_val("t3_btn_before", S_BTN, 0);
        expect_val("t3_no_press_yet", S_PCNT, 0);
        step(DEB_LAT - 1);
        check_all();
        expect_val("t3_btn_rise", S_BTN, 2);
        expect_val("t3_pressed_pulse", S_PRS, 2);
        step(1);
        check_all();
        expect_val("t3_pressed_end", S_PRS, 0);
        step(1);
        check_all();
        expect_val("t3_press_count", S_PCNT, 1);
        expect_val("t3_no_reset", S_RSEEN, 0);
        expect_val("t3_reset_low", S_RST, 0);
        step(20);
        check_all();
        button_n_i[1] = 1'b1;
        expect_val("t3_btn_release", S_BTN, 0);
        step(DEB_LAT + 2);
        check_all();
        mon_en = 1'b0;

        // 4: reset button
        button_n_i[0] = 1'b0;
        expect_val("t4_reset_before", S_RST, 0);
        step(DEB_LAT - 1);
        check_all();
        expect_val("t4_reset_rise", S_RST, 1);
        expect_val("t4_ready_fall", S_RDY, 0);
        expect_val("t4_btn0", S_BTN, 1);
        step(1);
        check_all();
        step(5);
        button_n_i[0] = 1'b1;
        expect_val("t4_release_hold", S_RST, 1);
        step(HOLD + DEB_LAT - 1);
        check_all();
        expect_val("t4_release_run", S_RST, 0);
        expect_val("t4_release_ready", S_RDY, 1);
        expect_val("t4_release_btn", S_BTN, 0);
        step(1);
        check_all();

        // 5: watchdog
`ifdef BOARD_RESET_WDT_EN
        repeat (4) begin
            step(49);
            kick();
        end
        expect_val("t5_kicked_fired", S_FIRED, 0);
        expect_val("t5_kicked_reset", S_RST, 0);
        check_all();
        step(WDT - 1);
        expect_val("t5_pre_timeout_reset", S_RST, 0);
        expect_val("t5_pre_timeout_fired", S_FIRED, 0);
        check_all();
        step(1);
        expect_val("t5_timeout_reset", S_RST, 1);
        expect_val("t5_timeout_fired", S_FIRED, 1);
        expect_val("t5_timeout_ready", S_RDY, 0);
        check_all();
        step(HOLD);
        expect_val("t5_rehold_reset", S_RST, 1);
        check_all();
        step(1);
        expect_val("t5_rerun_reset", S_RST, 0);
        expect_val("t5_fired_sticky", S_FIRED, 1);
        check_all();
        step(WDT - 1);
        kick();
        expect_val("t5_kick_wins_reset", S_RST, 0);
        check_all();
`else
        step(WDT + 10);
        expect_val("t5_nowdt_reset", S_RST, 0);
        expect_val("t5_nowdt_fired", S_FIRED, 0);
        check_all();
`endif

        // 6: async reset mid-HOLD and mid-debounce
        locked_i = '0;
        expect_val("t6_drop_reset", S_RST, 1);
        step(4);
        check_all();
        locked_i      = '1;
        button_n_i[1] = 1'b0;
        step(8);
        press_cnt = 0;
        mon_en    = 1'b1;
        #3;
        reset_n_i = 1'b0;
        #1;
        expect_val("t6_async_reset_o", S_RST, 1);
        expect_val("t6_async_ready_o", S_RDY, 0);
        expect_val("t6_async_button_o", S_BTN, 0);
        expect_val("t6_async_pressed_o", S_PRS, 0);
        expect_val("t6_async_fired", S_FIRED, 0);
        check_all();
        step(3);
        button_n_i[1] = 1'b1;
        step(2);
        reset_n_i = 1'b1;
        step(15);
        expect_val("t6_no_press", S_PCNT, 0);
        expect_val("t6_btn_idle", S_BTN, 0);
        check_all();
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
